score_display_ctrl: RTL and testbench
=====================================

Name: score_display_ctrl

Overview:
Owns the single shared 7-segment font ROM and sequences it to draw both players' two-digit scores into the video stream. Keeps per-player BCD score counters and detects the win condition. After a win, blinks the winner's score. Sits between the VGA timing generator and the pixel mux. Its output is ORed with the ball and paddle pixels.

Parameters:
- DIGIT_Y, 16: top row of all score digits.
- P1_X, 256: left column of P1 tens digit; ones digit at P1_X+24.
- P2_X, 344: left column of P2 tens digit; ones digit at P2_X+24.
- SEG_T, 4: segment thickness in pixels. Digit cell is 16 wide x 32 tall.
- WIN_SCORE, 11: score (binary value) at which a player wins.
- BLINK_LOG2, 5: blink half-period = 2^BLINK_LOG2 frames.

Ports:
- i_clk  in  1  system/pixel clock
- i_rst  in  1  synchronous, active-high reset
- i_px_x  in  10  current pixel column
- i_px_y  in  10  current pixel row
- i_video_on  in  1  visible-area flag
- i_frame_tick  in  1  one-cycle pulse per frame
- i_point  in  2  one-cycle score pulse; bit0 = P1, bit1 = P2
- i_clear  in  1  one-cycle pulse; restart match
- o_rom_addr  out  4  to font ROM address input
- i_rom_data  in  7  from font ROM, valid one cycle after o_rom_addr
- o_pixel  out  1  score pixel on
- o_p1_bcd  out  8  P1 score {tens,ones}
- o_p2_bcd  out  8  P2 score {tens,ones}
- o_win  out  2  sticky winner flags

Behaviour:
- Reset: all of the following are 0:
  - BCD counters
  - o_win
  - o_pixel
  - o_rom_addr
  - pipeline valid flags
  - blink counter and blink phase
- Counters: the BCD ones digit wraps 9→0 and carries into tens. At 99 the counter saturates.
- Counter updates are permitted only while o_win == 0. Pulses arriving while any o_win bit is set are ignored.
- Simultaneous points: both players increment in the same cycle.
- Win check uses the post-increment value. A player whose binary score equals WIN_SCORE sets their o_win bit on the next edge. If both players reach it on the same edge, o_win = 2'b11.
- i_clear zeroes both counters, o_win and the blink state. i_clear has priority over i_point in the same cycle.
- Blink: count i_frame_tick only while o_win != 0. Toggle blink phase every 2^BLINK_LOG2 ticks.
  - When blink phase = 1, pixels of the winning player(s) are suppressed.
  - When o_win == 0, blink phase is held at 0.
- Render pipeline, fixed 2-cycle latency from i_px_x/i_px_y to o_pixel:
  - Stage 0 (combinational):
    - Decode which of the 4 digit cells contains the pixel, using inclusive left/top and exclusive right/bottom bounds.
    - Drive o_rom_addr = that digit's BCD value; 4'd0 when no cell is hit.
    - Register local x (0–15), local y (0–31), the cell-hit flag, player id and i_video_on.
    - Cell-hit is forced to 0 for a tens digit equal to 0 (leading-zero blanking).
    - ROM codes 10–15 are never addressed.
  - Stage 1: combine the registered local coordinates with i_rom_data and register o_pixel = hit & video_on & ~blank & segment_on.
- Segment bit map of i_rom_data (T = SEG_T):
  - bit0 top: y < T
  - bit1 upper-left: x < T, y < 16
  - bit2 upper-right: x >= 16−T, y < 16
  - bit3 middle: 14 <= y < 18
  - bit4 lower-left: x < T, y >= 16
  - bit5 lower-right: x >= 16−T, y >= 16
  - bit6 bottom: y >= 32−T
- Score changes take effect at the rendering stage one cycle after the counter update. No tearing protection is required.
- Reset mid-frame: o_pixel is 0 on the first cycle after reset. Rendering is correct from cycle 2 onward.

Decomposition:
- Shared pong_pkg holds:
  - the segment bit-index constants (SEG_TOP..SEG_BOT)
  - the digit cell width/height (16/32)
  - the BLANK ROM code (4'd10)
- Sub-module bcd_score_counter (one instance per player): point/clear inputs; bcd and binary-equal-WIN outputs.
- Pixel pipeline and blink logic stay in the top module.

Test Plan:
- Reset, then 11 P1 pulses spaced 3 cycles apart:
  - o_p1_bcd steps to 8'h11.
  - o_win = 2'b01 on the edge after the 11th pulse.
  - A 12th pulse leaves o_p1_bcd = 8'h11.
- P1 at 10, P2 at 10, i_point = 2'b11 in one cycle → both BCD = 8'h11, o_win = 2'b11. Then i_clear together with i_point = 2'b01 → all zero.
- Carry: WIN_SCORE = 99, 9 pulses then 1 more → 8'h09 then 8'h10. After 99, further pulses are ignored.
- Render "7" for P2 at 8'h07, sweeping pixels:
  - o_rom_addr = 7 at (P2_X+24, DIGIT_Y).
  - o_pixel = 1 two cycles later at local (0,0) and at (15,20).
  - o_pixel = 0 at local (0,20).
  - P2 tens cell (score 0) is blank.
- Blink: P1 wins, BLINK_LOG2 = 1:
  - P1 pixels are on for 2 frame ticks, then off for 2.
  - P2 pixels stay steady.
  - i_clear stops the blinking.
- i_video_on = 0 inside a lit segment → o_pixel = 0 two cycles later. Assert reset mid-sweep → o_pixel = 0 the next cycle.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared constants and helpers for the score display: font cell geometry,
// segment bit positions of the 7-segment ROM word, and BCD conversion.
package pong_pkg;

   localparam int CELL_W = 16;
   localparam int CELL_H = 32;

   // Font ROM code that renders nothing; codes at or above it are never driven.
   localparam logic [3:0] ROM_BLANK = 4'd10;

   localparam int SEG_TOP = 0;
   localparam int SEG_UL  = 1;
   localparam int SEG_UR  = 2;
   localparam int SEG_MID = 3;
   localparam int SEG_LL  = 4;
   localparam int SEG_LR  = 5;
   localparam int SEG_BOT = 6;

   typedef struct packed {
      logic [3:0] lx;
      logic [4:0] ly;
      logic       hit;
      logic       player;
      logic       video_on;
   } px_stage_t;

   function automatic logic [6:0] bcd_to_bin(input logic [7:0] bcd);
      return 7'(bcd[7:4]) * 7'd10 + 7'(bcd[3:0]);
   endfunction

   // Which segments cover local cell coordinate (lx, ly) for thickness t.
   function automatic logic [6:0] seg_mask(input logic [3:0] lx,
                                           input logic [4:0] ly,
                                           input logic [4:0] t);
      logic [6:0] m;
      m          = '0;
      m[SEG_TOP] = (ly < t);
      m[SEG_UL]  = ({1'b0, lx} < t) && (ly < 5'd16);
      m[SEG_UR]  = ({1'b0, lx} >= 5'(CELL_W) - t) && (ly < 5'd16);
      m[SEG_MID] = (ly >= 5'd14) && (ly < 5'd18);
      m[SEG_LL]  = ({1'b0, lx} < t) && (ly >= 5'd16);
      m[SEG_LR]  = ({1'b0, lx} >= 5'(CELL_W) - t) && (ly >= 5'd16);
      m[SEG_BOT] = ({1'b0, ly} >= 6'(CELL_H) - {1'b0, t});
      return m;
   endfunction

endpackage

// File: rtl/score_display_ctrl_if.sv
// Signal bundle between the video/game side and the score display block,
// including the shared font ROM address/data pair.
interface score_display_ctrl_if;
   logic [9:0] i_px_x;
   logic [9:0] i_px_y;
   logic       i_video_on;
   logic       i_frame_tick;
   logic [1:0] i_point;
   logic       i_clear;
   logic [3:0] o_rom_addr;
   logic [6:0] i_rom_data;
   logic       o_pixel;
   logic [7:0] o_p1_bcd;
   logic [7:0] o_p2_bcd;
   logic [1:0] o_win;

   modport master (
      output i_px_x, i_px_y, i_video_on, i_frame_tick, i_point, i_clear, i_rom_data,
      input  o_rom_addr, o_pixel, o_p1_bcd, o_p2_bcd, o_win
   );

   modport slave (
      input  i_px_x, i_px_y, i_video_on, i_frame_tick, i_point, i_clear, i_rom_data,
      output o_rom_addr, o_pixel, o_p1_bcd, o_p2_bcd, o_win
   );
endinterface

// File: rtl/score_display_ctrl_counter.sv
// Two-digit BCD score counter for one player: saturates at 99 and reports
// whether the value it is about to hold equals the winning score.
module bcd_score_counter
   import pong_pkg::*;
#(
   parameter int WIN_SCORE = 11
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_point,
   input  logic       i_clear,
   input  logic       i_enable,
   output logic [7:0] o_bcd,
   output logic       o_win_next
);

   logic [7:0] r_bcd;
   logic [7:0] w_bcd_next;

   // NOTE: every variable written here gets a default first so no latch is inferred.
   always_comb begin
      w_bcd_next = r_bcd;
      if (i_clear) begin
         w_bcd_next = '0;
      end else if (i_point && i_enable && (r_bcd != 8'h99)) begin
         if (r_bcd[3:0] == 4'd9) begin
            w_bcd_next = {r_bcd[7:4] + 4'd1, 4'd0};
         end else begin
            w_bcd_next = {r_bcd[7:4], r_bcd[3:0] + 4'd1};
         end
      end
   end

   // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_bcd <= '0;
      end else begin
         r_bcd <= w_bcd_next;
      end
   end

   assign o_bcd      = r_bcd;
   // Looking at the post-increment value lets the win flag rise on the same edge.
   assign o_win_next = (bcd_to_bin(w_bcd_next) == 7'(WIN_SCORE));

endmodule

// File: rtl/score_display_ctrl.sv
// Draws both players' two-digit scores through one shared 7-segment font ROM,
// keeps the scores, latches the winner and blinks the winning score.
module score_display_ctrl
   import pong_pkg::*;
#(
   parameter int DIGIT_Y    = 16,
   parameter int P1_X       = 256,
   parameter int P2_X       = 344,
   parameter int SEG_T      = 4,
   parameter int WIN_SCORE  = 11,
   parameter int BLINK_LOG2 = 5
) (
   input  logic               i_clk,
   input  logic               i_rst,
   score_display_ctrl_if.slave bus
);

   localparam logic [9:0] X_P1T   = 10'(P1_X);
   localparam logic [9:0] X_P1O   = 10'(P1_X + 24);
   localparam logic [9:0] X_P2T   = 10'(P2_X);
   localparam logic [9:0] X_P2O   = 10'(P2_X + 24);
   localparam logic [9:0] CW      = 10'(CELL_W);
   localparam logic [9:0] Y_TOP   = 10'(DIGIT_Y);
   localparam logic [9:0] Y_END   = 10'(DIGIT_Y + CELL_H);

   logic [7:0] w_p1_bcd;
   logic [7:0] w_p2_bcd;
   logic       w_p1_win_next;
   logic       w_p2_win_next;
   logic       w_count_en;
   logic [1:0] r_win;

   assign w_count_en = (r_win == 2'b00);

   bcd_score_counter #(.WIN_SCORE(WIN_SCORE)) u_p1_score (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_point    (bus.i_point[0]),
      .i_clear    (bus.i_clear),
      .i_enable   (w_count_en),
      .o_bcd      (w_p1_bcd),
      .o_win_next (w_p1_win_next)
   );

   bcd_score_counter #(.WIN_SCORE(WIN_SCORE)) u_p2_score (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_point    (bus.i_point[1]),
      .i_clear    (bus.i_clear),
      .i_enable   (w_count_en),
      .o_bcd      (w_p2_bcd),
      .o_win_next (w_p2_win_next)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst || bus.i_clear) begin
         r_win <= 2'b00;
      end else if (w_count_en) begin
         r_win <= {w_p2_win_next, w_p1_win_next};
      end
   end

   logic [BLINK_LOG2-1:0] r_blink_cnt;
   logic                  r_blink_phase;

   // Blink state only runs once someone has won; otherwise it is parked at phase 0.
   always_ff @(posedge i_clk) begin
      if (i_rst || bus.i_clear || w_count_en) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b0;
      end else if (bus.i_frame_tick) begin
         r_blink_cnt <= r_blink_cnt + 1'b1;
         if (r_blink_cnt == '1) begin
            r_blink_phase <= ~r_blink_phase;
         end
      end
   end

   logic       w_in_row;
   logic       w_in_p1t;
   logic       w_in_p1o;
   logic       w_in_p2t;
   logic       w_in_p2o;
   logic [3:0] w_digit;
   logic [9:0] w_cell_x;
   logic       w_hit;
   logic       w_player;
   px_stage_t  w_s0;
   px_stage_t  r_s1;

   assign w_in_row = (bus.i_px_y >= Y_TOP) && (bus.i_px_y < Y_END);
   assign w_in_p1t = w_in_row && (bus.i_px_x >= X_P1T) && (bus.i_px_x < X_P1T + CW);
   assign w_in_p1o = w_in_row && (bus.i_px_x >= X_P1O) && (bus.i_px_x < X_P1O + CW);
   assign w_in_p2t = w_in_row && (bus.i_px_x >= X_P2T) && (bus.i_px_x < X_P2T + CW);
   assign w_in_p2o = w_in_row && (bus.i_px_x >= X_P2O) && (bus.i_px_x < X_P2O + CW);

   // A zero tens digit counts as a miss so the leading zero is never drawn.
   always_comb begin
      w_digit  = 4'd0;
      w_cell_x = X_P1T;
      w_hit    = 1'b0;
      w_player = 1'b0;
      if (w_in_p1t && (w_p1_bcd[7:4] != 4'd0)) begin
         w_digit  = w_p1_bcd[7:4];
         w_hit    = 1'b1;
      end else if (w_in_p1o) begin
         w_digit  = w_p1_bcd[3:0];
         w_cell_x = X_P1O;
         w_hit    = 1'b1;
      end else if (w_in_p2t && (w_p2_bcd[7:4] != 4'd0)) begin
         w_digit  = w_p2_bcd[7:4];
         w_cell_x = X_P2T;
         w_hit    = 1'b1;
         w_player = 1'b1;
      end else if (w_in_p2o) begin
         w_digit  = w_p2_bcd[3:0];
         w_cell_x = X_P2O;
         w_hit    = 1'b1;
         w_player = 1'b1;
      end
   end

   always_comb begin
      w_s0.lx       = 4'(bus.i_px_x - w_cell_x);
      w_s0.ly       = 5'(bus.i_px_y - Y_TOP);
      w_s0.hit      = w_hit;
      w_s0.player   = w_player;
      w_s0.video_on = bus.i_video_on;
   end

   assign bus.o_rom_addr = (i_rst || (w_digit >= ROM_BLANK)) ? 4'd0 : w_digit;

   logic w_seg_on;
   logic w_blank;
   logic r_pixel;

   assign w_seg_on = |(bus.i_rom_data & seg_mask(r_s1.lx, r_s1.ly, 5'(SEG_T)));
   assign w_blank  = r_blink_phase & r_win[r_s1.player];

   // The ROM word arrives one cycle after its address, aligned with r_s1.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s1    <= '0;
         r_pixel <= 1'b0;
      end else begin
         r_s1    <= w_s0;
         r_pixel <= r_s1.hit & r_s1.video_on & ~w_blank & w_seg_on;
      end
   end

   assign bus.o_pixel  = r_pixel;
   assign bus.o_p1_bcd = w_p1_bcd;
   assign bus.o_p2_bcd = w_p2_bcd;
   assign bus.o_win    = r_win;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl: three instances cover the default
// match, a 99-point match for carry/saturation, and a fast blink period.
module tb_score_display_ctrl;

   logic       clk;
   logic       rst;
   logic [9:0] px_x;
   logic [9:0] px_y;
   logic       video_on;
   logic [3:0] addr_a;
   int         n_checks;
   int         n_errors;

   score_display_ctrl_if if_a ();
   score_display_ctrl_if if_b ();
   score_display_ctrl_if if_c ();

   score_display_ctrl dut_a (.i_clk(clk), .i_rst(rst), .bus(if_a));
   score_display_ctrl #(.WIN_SCORE(99)) dut_b (.i_clk(clk), .i_rst(rst), .bus(if_b));
   score_display_ctrl #(.BLINK_LOG2(1)) dut_c (.i_clk(clk), .i_rst(rst), .bus(if_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign if_a.i_px_x = px_x;
   assign if_b.i_px_x = px_x;
   assign if_c.i_px_x = px_x;
   assign if_a.i_px_y = px_y;
   assign if_b.i_px_y = px_y;
   assign if_c.i_px_y = px_y;
   assign if_a.i_video_on = video_on;
   assign if_b.i_video_on = video_on;
   assign if_c.i_video_on = video_on;

   // Font ROM: bit0 top, 1 upper-left, 2 upper-right, 3 middle, 4 lower-left, 5 lower-right, 6 bottom.
   function automatic logic [6:0] font(input logic [3:0] a);
      case (a)
         4'd0: return 7'h77;
         4'd1: return 7'h24;
         4'd2: return 7'h5D;
         4'd3: return 7'h6D;
         4'd4: return 7'h2E;
         4'd5: return 7'h6B;
         4'd6: return 7'h7B;
         4'd7: return 7'h25;
         4'd8: return 7'h7F;
         4'd9: return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if_a.i_rom_data <= font(if_a.o_rom_addr);
      if_b.i_rom_data <= font(if_b.o_rom_addr);
      if_c.i_rom_data <= font(if_c.o_rom_addr);
   end

   function automatic logic [7:0] exp_bcd(input int n);
      return 8'(((n / 10) << 4) | (n % 10));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic point(input int dut, input logic [1:0] p);
      case (dut)
         0: if_a.i_point = p;
         1: if_b.i_point = p;
         default: if_c.i_point = p;
      endcase
      tick();
      if_a.i_point = 2'b00;
      if_b.i_point = 2'b00;
      if_c.i_point = 2'b00;
   endtask

   task automatic clear(input int dut, input logic [1:0] p);
      case (dut)
         0: begin if_a.i_clear = 1'b1; if_a.i_point = p; end
         1: begin if_b.i_clear = 1'b1; if_b.i_point = p; end
         default: begin if_c.i_clear = 1'b1; if_c.i_point = p; end
      endcase
      tick();
      if_a.i_clear = 1'b0;
      if_b.i_clear = 1'b0;
      if_c.i_clear = 1'b0;
      if_a.i_point = 2'b00;
      if_b.i_point = 2'b00;
      if_c.i_point = 2'b00;
   endtask

   task automatic frame_c();
      if_c.i_frame_tick = 1'b1;
      tick();
      if_c.i_frame_tick = 1'b0;
   endtask

   // Present one pixel, capture instance A's ROM address, then wait out the 2-cycle latency.
   task automatic probe(input int x, input int y, input logic v);
      px_x     = 10'(x);
      px_y     = 10'(y);
      video_on = v;
      #1;
      addr_a = if_a.o_rom_addr;
      tick();
      tick();
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst      = 1'b1;
      px_x     = '0;
      px_y     = '0;
      video_on = 1'b0;
      if_a.i_point = '0; if_a.i_clear = 1'b0; if_a.i_frame_tick = 1'b0;
      if_b.i_point = '0; if_b.i_clear = 1'b0; if_b.i_frame_tick = 1'b0;
      if_c.i_point = '0; if_c.i_clear = 1'b0; if_c.i_frame_tick = 1'b0;
      tick();
      tick();
      check("rst_rom_addr", if_a.o_rom_addr, 4'd0);
      rst = 1'b0;
      tick();
      check("rst_p1_bcd", if_a.o_p1_bcd, 8'h00);
      check("rst_p2_bcd", if_a.o_p2_bcd, 8'h00);
      check("rst_win", if_a.o_win, 2'b00);
      check("rst_pixel", if_a.o_pixel, 1'b0);

      // Eleven spaced P1 points: win flag appears with the eleventh.
      for (int i = 1; i <= 11; i++) begin
         point(0, 2'b01);
         check($sformatf("p1_step%0d_bcd", i), if_a.o_p1_bcd, exp_bcd(i));
         check($sformatf("p1_step%0d_win", i), if_a.o_win, (i == 11) ? 2'b01 : 2'b00);
         tick();
         tick();
      end
      point(0, 2'b01);
      check("p1_after_win_bcd", if_a.o_p1_bcd, 8'h11);
      check("p1_after_win_p2", if_a.o_p2_bcd, 8'h00);

      // Simultaneous win, then clear beating a same-cycle point.
      clear(0, 2'b00);
      for (int i = 0; i < 10; i++) point(0, 2'b11);
      check("both10_p1", if_a.o_p1_bcd, 8'h10);
      check("both10_p2", if_a.o_p2_bcd, 8'h10);
      check("both10_win", if_a.o_win, 2'b00);
      point(0, 2'b11);
      check("both11_p1", if_a.o_p1_bcd, 8'h11);
      check("both11_p2", if_a.o_p2_bcd, 8'h11);
      check("both11_win", if_a.o_win, 2'b11);
      clear(0, 2'b01);
      check("clear_p1", if_a.o_p1_bcd, 8'h00);
      check("clear_p2", if_a.o_p2_bcd, 8'h00);
      check("clear_win", if_a.o_win, 2'b00);

      // Carry and saturation on the 99-point instance.
      for (int i = 0; i < 9; i++) point(1, 2'b01);
      check("carry_09", if_b.o_p1_bcd, 8'h09);
      point(1, 2'b01);
      check("carry_10", if_b.o_p1_bcd, 8'h10);
      for (int i = 0; i < 88; i++) point(1, 2'b01);
      check("carry_98", if_b.o_p1_bcd, 8'h98);
      check("carry_98_win", if_b.o_win, 2'b00);
      point(1, 2'b01);
      check("carry_99", if_b.o_p1_bcd, 8'h99);
      check("carry_99_win", if_b.o_win, 2'b01);
      for (int i = 0; i < 3; i++) point(1, 2'b01);
      check("sat_99", if_b.o_p1_bcd, 8'h99);

      // Render P2 = 07 on instance A.
      for (int i = 0; i < 7; i++) point(0, 2'b10);
      check("render_p2_bcd", if_a.o_p2_bcd, 8'h07);
      probe(368, 16, 1'b1);
      check("render_addr_7", addr_a, 4'd7);
      check("render_top_0_0", if_a.o_pixel, 1'b1);
      probe(383, 36, 1'b1);
      check("render_lr_15_20", if_a.o_pixel, 1'b1);
      probe(368, 36, 1'b1);
      check("render_ll_0_20", if_a.o_pixel, 1'b0);
      probe(383, 47, 1'b1);
      check("render_lr_15_31", if_a.o_pixel, 1'b1);
      probe(384, 16, 1'b1);
      check("render_right_edge", if_a.o_pixel, 1'b0);
      probe(368, 48, 1'b1);
      check("render_bottom_edge_addr", addr_a, 4'd0);
      check("render_bottom_edge", if_a.o_pixel, 1'b0);
      probe(344, 16, 1'b1);
      check("render_p2_tens_addr", addr_a, 4'd0);
      check("render_p2_tens_blank", if_a.o_pixel, 1'b0);
      probe(256, 16, 1'b1);
      check("render_p1_tens_blank", if_a.o_pixel, 1'b0);
      probe(280, 16, 1'b1);
      check("render_p1_ones_zero", if_a.o_pixel, 1'b1);

      // Blink on instance C: P1 = 11 wins, P2 = 3 stays steady.
      for (int i = 0; i < 3; i++) point(2, 2'b10);
      for (int i = 0; i < 11; i++) point(2, 2'b01);
      check("blink_win", if_c.o_win, 2'b01);
      probe(295, 21, 1'b1);
      check("blink_p1_k0", if_c.o_pixel, 1'b1);
      for (int k = 1; k <= 6; k++) begin
         frame_c();
         probe(295, 21, 1'b1);
         check($sformatf("blink_p1_k%0d", k), if_c.o_pixel, ((k / 2) % 2 == 0) ? 1'b1 : 1'b0);
         probe(368, 16, 1'b1);
         check($sformatf("blink_p2_k%0d", k), if_c.o_pixel, 1'b1);
      end
      clear(2, 2'b00);
      check("blink_clear_win", if_c.o_win, 2'b00);
      frame_c();
      frame_c();
      probe(280, 16, 1'b1);
      check("blink_clear_p1_on", if_c.o_pixel, 1'b1);

      // Video gating, then reset in the middle of a lit run.
      probe(368, 16, 1'b0);
      check("video_off", if_a.o_pixel, 1'b0);
      probe(368, 16, 1'b1);
      check("pre_reset_lit", if_a.o_pixel, 1'b1);
      rst = 1'b1;
      tick();
      check("reset_pixel", if_a.o_pixel, 1'b0);
      check("reset_p2_bcd", if_a.o_p2_bcd, 8'h00);
      rst = 1'b0;
      tick();
      check("post_reset_c1", if_a.o_pixel, 1'b0);
      tick();
      check("post_reset_c2", if_a.o_pixel, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
